// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants for the VGA signal generator: the default 640x480 @ 60 Hz
// timing, the totals and sync window derived from it, and the bit layout of
// the CONFIG_COLOURS word.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;

    // Vertical timing, in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;

    // Board clocks per pixel
    localparam int CLK_DIV = 4;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Counter and bus widths
    localparam int CNT_W    = 10;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 12;
    localparam int CONFIG_W = 2 * COLOUR_W;

    // CONFIG_COLOURS fields: foreground for pixel bit 1, background for bit 0
    localparam int FG_LSB = 12;
    localparam int BG_LSB = 0;

endpackage

// File: rtl/vga_sig_gen_if.sv
// vga_sig_gen_if
// Signals between the VGA generator, the frame-buffer read port and the
// board pins.
//   CONFIG_COLOURS : {foreground[11:0], background[11:0]}
//   VGA_ADDR       : frame-buffer read address {row[6:0], col[7:0]}
//   VGA_DATA       : frame-buffer read data, one CLK after VGA_ADDR
//   DPR_CLK        : pixel strobe for the RAM read port
//   HS, VS         : active-low syncs
//   COLOUR_OUT     : RGB 4:4:4, zero while blanking
//   FRAME_START    : one-CLK pulse at each frame start
// master = generator side, slave = RAM/pin side.
interface vga_sig_gen_if;
    import vga_pkg::*;

    logic [CONFIG_W-1:0] CONFIG_COLOURS;
    logic [ADDR_W-1:0]   VGA_ADDR;
    logic                VGA_DATA;
    logic                DPR_CLK;
    logic                HS;
    logic                VS;
    logic [COLOUR_W-1:0] COLOUR_OUT;
    logic                FRAME_START;

    modport master (
        input  CONFIG_COLOURS,
        input  VGA_DATA,
        output VGA_ADDR,
        output DPR_CLK,
        output HS,
        output VS,
        output COLOUR_OUT,
        output FRAME_START
    );

    modport slave (
        output CONFIG_COLOURS,
        output VGA_DATA,
        input  VGA_ADDR,
        input  DPR_CLK,
        input  HS,
        input  VS,
        input  COLOUR_OUT,
        input  FRAME_START
    );

endinterface

// File: rtl/generic_counter.sv
// generic_counter
// Wrapping up-counter 0..MAX that advances while ENABLE is high.
//   CLK      : clock
//   RESET    : asynchronous active-high reset, clears COUNT
//   ENABLE   : advance on this clock
//   COUNT    : current value
//   TRIG_OUT : terminal count (COUNT == MAX); the counter wraps on the next
//              enabled edge. Held for as long as COUNT sits at MAX, so callers
//              AND it with their own enable to get a single-cycle wrap pulse.
module generic_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] COUNT,
    output logic             TRIG_OUT
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (ENABLE) begin
            if (COUNT == MAX_V) begin
                COUNT <= '0;
            end else begin
                COUNT <= COUNT + WIDTH'(1);
            end
        end
    end

    assign TRIG_OUT = (COUNT == MAX_V);

endmodule

// File: rtl/vga_sig_gen.sv
// vga_sig_gen
// VGA timing and pixel generator. Divides CLK down to a pixel strobe, runs the
// horizontal/vertical raster counters, reads a 160x120 1-bpp frame buffer at
// quarter resolution and drives registered syncs and colour.
//   CLK   : 100 MHz system clock
//   RESET : asynchronous active-high reset
//   bus   : vga_sig_gen_if master (frame-buffer port, config, VGA pins)
// HS, VS and COLOUR_OUT all register on the same pixel strobe from the same
// counter values, so they share one pixel (CLK_DIV clocks) of latency and stay
// aligned to each other.
module vga_sig_gen #(
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP,
    parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
    input  logic          CLK,
    input  logic          RESET,
    vga_sig_gen_if.master bus
);

    import vga_pkg::*;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_LAST = H_VIS + H_FP + H_SYNC + H_BP - 1;
    localparam int V_LAST = V_VIS + V_FP + V_SYNC + V_BP - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                pix_en;
    logic [CNT_W-1:0]    h_cnt;
    logic                h_tc;
    logic                line_end;
    logic [CNT_W-1:0]    v_cnt;
    logic                v_tc;
    logic                frame_wrap;

    logic                active;
    logic                hs_low;
    logic                vs_low;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic [COLOUR_W-1:0] pix_colour;

    generic_counter #(
        .WIDTH (DIV_W),
        .MAX   (CLK_DIV - 1)
    ) u_div (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (1'b1),
        .COUNT    (div_cnt),
        .TRIG_OUT (pix_en)
    );

    generic_counter #(
        .WIDTH (CNT_W),
        .MAX   (H_LAST)
    ) u_h_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (pix_en),
        .COUNT    (h_cnt),
        .TRIG_OUT (h_tc)
    );

    // h_tc is held for a whole pixel; qualify it so the line advances once.
    assign line_end = h_tc & pix_en;

    generic_counter #(
        .WIDTH (CNT_W),
        .MAX   (V_LAST)
    ) u_v_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (line_end),
        .COUNT    (v_cnt),
        .TRIG_OUT (v_tc)
    );

    assign frame_wrap = line_end & v_tc;

    // Strobe taken straight from the divider count for the RAM read port.
    assign bus.DPR_CLK = (div_cnt == DIV_LAST);

    // Each frame-buffer pixel covers a 4x4 block of screen pixels.
    assign bus.VGA_ADDR = {v_cnt[8:2], h_cnt[9:2]};

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_low = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_low = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    assign fg_colour  = bus.CONFIG_COLOURS[FG_LSB +: COLOUR_W];
    assign bg_colour  = bus.CONFIG_COLOURS[BG_LSB +: COLOUR_W];
    assign pix_colour = bus.VGA_DATA ? fg_colour : bg_colour;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.HS          <= 1'b1;
            bus.VS          <= 1'b1;
            bus.COLOUR_OUT  <= '0;
            bus.FRAME_START <= 1'b0;
        end else begin
            // High for the first CLK in which the counters sit at (0,0).
            bus.FRAME_START <= frame_wrap;
            if (pix_en) begin
                bus.HS         <= ~hs_low;
                bus.VS         <= ~vs_low;
                bus.COLOUR_OUT <= active ? pix_colour : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sig_gen.sv
module tb_vga_sig_gen;

    // Reduced raster so that whole frames fit in a short run; the DUT is
    // fully parameterised and the rules are identical at 640x480.
    localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;   // 56 pixels per line
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;   // 31 lines per frame
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = 4 * FRAME_PIX;           // 6944 CLK
    localparam int LINE_CLK  = 4 * HT;                  // 224 CLK
    localparam int HSS = H_VIS + H_FP;
    localparam int VSS = V_VIS + V_FP;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic [23:0] cfg = 24'h0;
    logic ram_q = 1'b0;
    bit   mem [0:32767];

    int errors = 0;
    int checks = 0;

    vga_sig_gen_if bus ();

    vga_sig_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Synchronous frame-buffer RAM model: data one CLK after the address.
    always @(posedge CLK) ram_q <= mem[bus.VGA_ADDR];
    assign bus.VGA_DATA       = ram_q;
    assign bus.CONFIG_COLOURS = cfg;

    // Clock edges since reset release, and the colour word seen at the most
    // recent pixel edge (every 4th edge).
    int n_edge = 0;
    logic [23:0] cfg_pix = 24'h0;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) n_edge <= 0;
        else       n_edge <= n_edge + 1;
    end
    always @(posedge CLK) begin
        if (!RESET && ((n_edge + 1) % 4 == 0)) cfg_pix <= cfg;
    end

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        fs;
        logic        dpr;
        logic [11:0] col;
        logic [14:0] addr;
    } exp_t;

    // Raster model: after n edges, k pixel steps have happened; the counters
    // sit at pixel k of the frame and the registered outputs describe pixel k-1.
    function automatic exp_t model(int n);
        exp_t e;
        int k, p, h, v, q, hq, vq;
        k = n / 4;
        p = k % FRAME_PIX;
        h = p % HT;
        v = p / HT;
        e.addr = 15'((v / 4) * 256 + h / 4);
        e.dpr  = (n % 4 == 3);
        e.fs   = (n > 0) && (n % 4 == 0) && (k % FRAME_PIX == 0);
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.col  = 12'h000;
        if (k > 0) begin
            q  = (k - 1) % FRAME_PIX;
            hq = q % HT;
            vq = q / HT;
            e.hs = !(hq >= HSS && hq < HSS + H_SYNC);
            e.vs = !(vq >= VSS && vq < VSS + V_SYNC);
            if (hq < H_VIS && vq < V_VIS)
                e.col = mem[(vq / 4) * 256 + hq / 4] ? cfg_pix[23:12] : cfg_pix[11:0];
        end
        return e;
    endfunction

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < 32768; i++) mem[i] = bit'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
        cfg = 24'h123_456;
        #2 RESET = 1'b1;
        repeat (20) begin
            @(posedge CLK); #1;
            checks++;
            if (bus.HS !== 1'b1 || bus.VS !== 1'b1 || bus.COLOUR_OUT !== 12'h000 ||
                bus.FRAME_START !== 1'b0 || bus.VGA_ADDR !== 15'h0) begin
                errors++;
                $display("FAIL reset_hold: hs=%b vs=%b col=%h fs=%b addr=%h, need 1 1 000 0 0000",
                         bus.HS, bus.VS, bus.COLOUR_OUT, bus.FRAME_START, bus.VGA_ADDR);
            end
        end
        RESET = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (bus.DPR_CLK !== ((i == 3) || (i == 7))) begin
                errors++;
                $display("FAIL first_strobe edge %0d: dpr=%b", i, bus.DPR_CLK);
            end
            checks++;
            if (bus.COLOUR_OUT !== ((i >= 4) ? 12'h456 : 12'h000)) begin
                errors++;
                $display("FAIL first_pixel edge %0d: col=%h need %h", i, bus.COLOUR_OUT,
                         (i >= 4) ? 12'h456 : 12'h000);
            end
            checks++;
            if (bus.HS !== 1'b1 || bus.VS !== 1'b1) begin
                errors++;
                $display("FAIL sync_after_release edge %0d: hs=%b vs=%b need 1 1", i, bus.HS, bus.VS);
            end
        end
    endtask

    task automatic test_raster_random();
        exp_t e;
        int local_err;
        local_err = 0;
        fill_mem_random();
        cfg = $urandom;
        do_reset();
        for (int i = 0; i < FRAME_CLK + 3 * LINE_CLK && local_err < 50; i++) begin
            @(posedge CLK); #1;
            e = model(n_edge);
            checks++;
            if (bus.COLOUR_OUT !== e.col) begin
                errors++; local_err++;
                $display("FAIL raster_colour n=%0d: got %h need %h", n_edge, bus.COLOUR_OUT, e.col);
            end
            checks++;
            if (bus.HS !== e.hs || bus.VS !== e.vs) begin
                errors++; local_err++;
                $display("FAIL raster_sync n=%0d: hs=%b vs=%b need %b %b", n_edge, bus.HS, bus.VS, e.hs, e.vs);
            end
            checks++;
            if (bus.VGA_ADDR !== e.addr) begin
                errors++; local_err++;
                $display("FAIL raster_addr n=%0d: got %h need %h", n_edge, bus.VGA_ADDR, e.addr);
            end
            checks++;
            if (bus.FRAME_START !== e.fs || bus.DPR_CLK !== e.dpr) begin
                errors++; local_err++;
                $display("FAIL raster_strobes n=%0d: fs=%b dpr=%b need %b %b", n_edge, bus.FRAME_START,
                         bus.DPR_CLK, e.fs, e.dpr);
            end
            if ($urandom_range(0, 63) == 0) cfg = $urandom;
        end
    endtask

    task automatic test_hsync();
        int falls[$];
        int rises[$];
        logic prev;
        int f0, f1, r0;
        do_reset();
        prev = 1'b1;
        for (int i = 0; i < 3 * LINE_CLK; i++) begin
            @(posedge CLK); #1;
            if (prev === 1'b1 && bus.HS === 1'b0) falls.push_back(n_edge);
            if (prev === 1'b0 && bus.HS === 1'b1) rises.push_back(n_edge);
            prev = bus.HS;
        end
        f0 = (falls.size() > 0) ? falls[0] : -1;
        f1 = (falls.size() > 1) ? falls[1] : -1;
        r0 = (rises.size() > 0) ? rises[0] : -1;
        checks++;
        if (f0 != 4 * HSS + 4) begin
            errors++;
            $display("FAIL hs_fall: at %0d need %0d", f0, 4 * HSS + 4);
        end
        checks++;
        if (r0 - f0 != 4 * H_SYNC) begin
            errors++;
            $display("FAIL hs_width: %0d need %0d", r0 - f0, 4 * H_SYNC);
        end
        checks++;
        if (f1 - f0 != LINE_CLK) begin
            errors++;
            $display("FAIL line_period: %0d need %0d", f1 - f0, LINE_CLK);
        end
    endtask

    task automatic test_vsync_frame();
        int vfalls[$];
        int vrises[$];
        int fs_at[$];
        logic prev_vs;
        int run, max_run;
        int f0, f1, r0, s0, s1;
        fill_mem_random();
        do_reset();
        prev_vs = 1'b1;
        run = 0;
        max_run = 0;
        for (int i = 0; i < 2 * FRAME_CLK + 8; i++) begin
            @(posedge CLK); #1;
            if (prev_vs === 1'b1 && bus.VS === 1'b0) vfalls.push_back(n_edge);
            if (prev_vs === 1'b0 && bus.VS === 1'b1) vrises.push_back(n_edge);
            prev_vs = bus.VS;
            if (bus.FRAME_START === 1'b1) begin
                if (run == 0) fs_at.push_back(n_edge);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        f0 = (vfalls.size() > 0) ? vfalls[0] : -1;
        f1 = (vfalls.size() > 1) ? vfalls[1] : -1;
        r0 = (vrises.size() > 0) ? vrises[0] : -1;
        s0 = (fs_at.size() > 0) ? fs_at[0] : -1;
        s1 = (fs_at.size() > 1) ? fs_at[1] : -1;
        checks++;
        if (f0 != 4 * (VSS * HT + 1)) begin
            errors++;
            $display("FAIL vs_fall: at %0d need %0d", f0, 4 * (VSS * HT + 1));
        end
        checks++;
        if (r0 - f0 != 4 * V_SYNC * HT) begin
            errors++;
            $display("FAIL vs_width: %0d need %0d", r0 - f0, 4 * V_SYNC * HT);
        end
        checks++;
        if (f1 - f0 != FRAME_CLK) begin
            errors++;
            $display("FAIL vs_period: %0d need %0d", f1 - f0, FRAME_CLK);
        end
        checks++;
        if (fs_at.size() != 2 || s0 != FRAME_CLK || s1 - s0 != FRAME_CLK) begin
            errors++;
            $display("FAIL frame_start_period: count=%0d first=%0d second=%0d need 2 %0d %0d",
                     fs_at.size(), s0, s1, FRAME_CLK, 2 * FRAME_CLK);
        end
        checks++;
        if (max_run != 1) begin
            errors++;
            $display("FAIL frame_start_width: %0d CLK need 1", max_run);
        end
    endtask

    task automatic test_colour_map();
        int k, q, hq, vq, p;
        int n_f00, n_00f;
        for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
        mem[0] = 1'b1;
        cfg = 24'hF00_00F;
        n_f00 = 0;
        n_00f = 0;
        do_reset();
        for (int n = 1; n <= 4 * ((V_VIS - 1) * HT + H_VIS) + 4; n++) begin
            @(posedge CLK); #1;
            if (n % 4 == 0) begin
                k  = n / 4;
                q  = k - 1;
                hq = q % HT;
                vq = q / HT;
                if (hq < 4 && vq < 4) begin
                    n_f00++;
                    checks++;
                    if (bus.COLOUR_OUT !== 12'hF00) begin
                        errors++;
                        $display("FAIL fg_block (%0d,%0d): got %h need f00", hq, vq, bus.COLOUR_OUT);
                    end
                end else if (hq == 4 && vq == 0) begin
                    n_00f++;
                    checks++;
                    if (bus.COLOUR_OUT !== 12'h00F) begin
                        errors++;
                        $display("FAIL bg_pixel (4,0): got %h need 00f", bus.COLOUR_OUT);
                    end
                end else if (hq >= H_VIS) begin
                    checks++;
                    if (bus.COLOUR_OUT !== 12'h000) begin
                        errors++;
                        $display("FAIL h_blank (%0d,%0d): got %h need 000", hq, vq, bus.COLOUR_OUT);
                    end
                end
                p = k % FRAME_PIX;
                if (p % HT == H_VIS - 1 && p / HT == V_VIS - 1) begin
                    // Last visible pixel (39,23) -> {row 5, col 9}
                    checks++;
                    if (bus.VGA_ADDR !== 15'h0509) begin
                        errors++;
                        $display("FAIL last_vis_addr: got %h need 0509", bus.VGA_ADDR);
                    end
                end
            end
        end
        checks++;
        if (n_f00 != 16 || n_00f != 1) begin
            errors++;
            $display("FAIL colour_coverage: fg=%0d bg=%0d need 16 1", n_f00, n_00f);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic prev_vs;
        int vfall;
        int local_err;
        fill_mem_random();
        cfg = $urandom;
        do_reset();
        repeat (4 * (20 * HT + 30) + 2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.HS !== 1'b1 || bus.VS !== 1'b1 || bus.COLOUR_OUT !== 12'h000 ||
            bus.FRAME_START !== 1'b0 || bus.VGA_ADDR !== 15'h0) begin
            errors++;
            $display("FAIL mid_reset_immediate: hs=%b vs=%b col=%h fs=%b addr=%h",
                     bus.HS, bus.VS, bus.COLOUR_OUT, bus.FRAME_START, bus.VGA_ADDR);
        end
        repeat (3) begin
            @(posedge CLK); #1;
            checks++;
            if (bus.HS !== 1'b1 || bus.VS !== 1'b1 || bus.COLOUR_OUT !== 12'h000 || bus.VGA_ADDR !== 15'h0) begin
                errors++;
                $display("FAIL mid_reset_hold: hs=%b vs=%b col=%h addr=%h",
                         bus.HS, bus.VS, bus.COLOUR_OUT, bus.VGA_ADDR);
            end
        end
        RESET = 1'b0;
        prev_vs = 1'b1;
        vfall = -1;
        local_err = 0;
        for (int i = 0; i < 4 * (VSS * HT + 1) + 8 && local_err < 50; i++) begin
            @(posedge CLK); #1;
            if (prev_vs === 1'b1 && bus.VS === 1'b0 && vfall < 0) vfall = n_edge;
            prev_vs = bus.VS;
            e = model(n_edge);
            checks++;
            if (bus.COLOUR_OUT !== e.col || bus.HS !== e.hs || bus.VS !== e.vs) begin
                errors++; local_err++;
                $display("FAIL restart_raster n=%0d: col=%h hs=%b vs=%b need %h %b %b",
                         n_edge, bus.COLOUR_OUT, bus.HS, bus.VS, e.col, e.hs, e.vs);
            end
        end
        checks++;
        if (vfall != 4 * (VSS * HT + 1)) begin
            errors++;
            $display("FAIL restart_vs_fall: at %0d need %0d", vfall, 4 * (VSS * HT + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raster_random();
        test_hsync();
        test_vsync_frame();
        test_colour_map();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
